// File: rtl/rstatus_exception_queue_pkg.sv
// Shared opcode/ALU constants, status codes and the overflow-fault classifier
// used by the rstatus exception queue.
package rstatus_pkg;

    localparam int CODE_WIDTH = 3;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic [CODE_WIDTH-1:0] {
        RS_NONE = 3'd0,
        RS_ADD  = 3'd1,
        RS_ADDI = 3'd2,
        RS_SUB  = 3'd3,
        RS_MUL  = 3'd4,
        RS_DIV  = 3'd5
    } rs_code_e;

    // Order matters: addi wins over any ALU field, and mul/div match on the ALU field alone.
    function automatic rs_code_e classify(input logic [4:0] opcode, input logic [4:0] alu_op);
        if (opcode == OP_RTYPE && alu_op == ALU_ADD) return RS_ADD;
        if (opcode == OP_ADDI)                       return RS_ADDI;
        if (opcode == OP_RTYPE && alu_op == ALU_SUB) return RS_SUB;
        if (alu_op == ALU_MUL)                       return RS_MUL;
        if (alu_op == ALU_DIV)                       return RS_DIV;
        return RS_NONE;
    endfunction

endpackage

// File: rtl/rstatus_exception_queue_if.sv
// Ready/valid write port carrying $rstatus updates from the exception queue to writeback.
interface rstatus_exception_queue_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  wb_valid;
    logic                  wb_ready;
    logic [4:0]            wb_reg;
    logic [DATA_WIDTH-1:0] wb_data;

    modport master (output wb_valid, output wb_reg, output wb_data, input wb_ready);
    modport slave  (input wb_valid, input wb_reg, input wb_data, output wb_ready);
endinterface

// File: rtl/rstatus_exception_queue_fifo.sv
// Synchronous FIFO of status codes; pointers carry one extra wrap bit so that
// full and empty are distinguishable without an occupancy counter.
module rstatus_fifo #(
    parameter int DEPTH      = 4,
    parameter int CODE_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [CODE_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [CODE_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [CODE_WIDTH-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on a full FIFO frees the slot the same cycle, so the push may proceed.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rstatus_exception_queue.sv
// Classifies execute-stage overflow faults, queues their status codes and
// presents each one to writeback as a write of $rstatus.
module rstatus_exception_queue
    import rstatus_pkg::*;
#(
    parameter int         DATA_WIDTH  = 32,
    parameter int         DEPTH       = 4,
    parameter int         CNT_WIDTH   = 8,
    parameter logic [4:0] RSTATUS_REG = 5'd30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [4:0]            ex_opcode,
    input  logic [4:0]            ex_alu_op,
    input  logic                  ex_ovf,
    input  logic                  ex_flush,
    input  logic                  clr_sticky,
    rstatus_exception_queue_if.master wb,
    output logic [DATA_WIDTH-1:0] status_last,
    output logic [CNT_WIDTH-1:0]  exc_count,
    output logic                  fifo_full,
    output logic                  drop_sticky
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    rs_code_e              code;
    logic                  fault;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  fifo_empty;
    logic [CODE_WIDTH-1:0] head_code;

    assign code  = classify(ex_opcode, ex_alu_op);
    assign fault = ex_valid & ex_ovf & ~ex_flush & (code != RS_NONE);
    assign pop   = wb.wb_valid & wb.wb_ready;
    assign push  = fault & (~fifo_full | pop);
    assign drop  = fault & fifo_full & ~pop;

    rstatus_fifo #(
        .DEPTH      (DEPTH),
        .CODE_WIDTH (CODE_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (code),
        .pop       (pop),
        .head_data (head_code),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Writeback sees only registered FIFO state; the head is masked to zero when empty
    // so the unreset storage never leaks onto wb_data.
    assign wb.wb_valid = ~fifo_empty;
    assign wb.wb_reg   = RSTATUS_REG;
    assign wb.wb_data  = fifo_empty ? '0 : DATA_WIDTH'(head_code);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exc_count <= '0;
        end else if (fault && exc_count != CNT_MAX) begin
            exc_count <= exc_count + 1'b1;
        end
    end

    // A fault in the same cycle as clr_sticky takes precedence for the last code.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_last <= '0;
        end else if (fault) begin
            status_last <= DATA_WIDTH'(code);
        end else if (clr_sticky) begin
            status_last <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_sticky <= 1'b0;
        end else if (drop) begin
            drop_sticky <= 1'b1;
        end else if (clr_sticky) begin
            drop_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rstatus_exception_queue.sv
// Self-checking bench for rstatus_exception_queue: vector table for the code map,
// scripted sequences for queueing, drops, clears, async reset and saturation.
module tb_rstatus_exception_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_opcode = '0;
    logic [4:0]  ex_alu_op = '0;
    logic        ex_ovf = 1'b0;
    logic        ex_flush = 1'b0;
    logic        clr_sticky = 1'b0;
    logic [31:0] status_last;
    logic [7:0]  exc_count;
    logic        fifo_full;
    logic        drop_sticky;

    rstatus_exception_queue_if #(.DATA_WIDTH(32)) wb ();

    rstatus_exception_queue #(
        .DATA_WIDTH  (32),
        .DEPTH       (4),
        .CNT_WIDTH   (8),
        .RSTATUS_REG (5'd30)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_opcode   (ex_opcode),
        .ex_alu_op   (ex_alu_op),
        .ex_ovf      (ex_ovf),
        .ex_flush    (ex_flush),
        .clr_sticky  (clr_sticky),
        .wb          (wb.master),
        .status_last (status_last),
        .exc_count   (exc_count),
        .fifo_full   (fifo_full),
        .drop_sticky (drop_sticky)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;
    int sb[$];

    typedef struct {
        logic       valid;
        logic [4:0] op;
        logic [4:0] alu;
        logic       ovf;
        logic       flush;
        int         code;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] alu, input bit enq, input int code);
        ex_valid  = 1'b1;
        ex_opcode = op;
        ex_alu_op = alu;
        ex_ovf    = 1'b1;
        ex_flush  = 1'b0;
        if (enq) sb.push_back(code);
        cycle();
        ex_valid = 1'b0;
        ex_ovf   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wb_valid"}, wb.wb_valid, 0);
        check({tag, "_wb_data"}, wb.wb_data, 0);
        check({tag, "_wb_reg"}, wb.wb_reg, 30);
        check({tag, "_status_last"}, status_last, 0);
        check({tag, "_exc_count"}, exc_count, 0);
        check({tag, "_fifo_full"}, fifo_full, 0);
        check({tag, "_drop_sticky"}, drop_sticky, 0);
    endtask

    // Scoreboard: every accepted writeback transfer must match the oldest expected code.
    always @(negedge clock) begin
        if (!reset && wb.wb_valid && wb.wb_ready) begin
            if (sb.size() == 0) check("sb_unexpected_pop", 1, 0);
            else check("sb_wb_data", wb.wb_data, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;
        int exp_last;

        vecs[0]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1};
        vecs[1]  = '{1'b1, 5'd5, 5'd3, 1'b1, 1'b0, 2};
        vecs[2]  = '{1'b1, 5'd0, 5'd1, 1'b1, 1'b0, 3};
        vecs[3]  = '{1'b1, 5'd0, 5'd6, 1'b1, 1'b0, 4};
        vecs[4]  = '{1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 5};
        vecs[5]  = '{1'b1, 5'd3, 5'd6, 1'b1, 1'b0, 4};
        vecs[6]  = '{1'b1, 5'd0, 5'd2, 1'b1, 1'b0, 0};
        vecs[7]  = '{1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 0};
        vecs[8]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 0};
        vecs[9]  = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 0};
        vecs[10] = '{1'b1, 5'd0, 5'd1, 1'b0, 1'b0, 0};
        vecs[11] = '{1'b1, 5'd5, 5'd7, 1'b1, 1'b0, 2};

        wb.wb_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_zero("in_reset");
        reset = 1'b0;
        cycle();
        check_zero("after_reset");

        // Code map, one instruction at a time with writeback always ready.
        exp_cnt  = 0;
        exp_last = 0;
        for (int i = 0; i < 12; i++) begin
            ex_valid  = vecs[i].valid;
            ex_opcode = vecs[i].op;
            ex_alu_op = vecs[i].alu;
            ex_ovf    = vecs[i].ovf;
            ex_flush  = vecs[i].flush;
            if (vecs[i].code != 0) begin
                sb.push_back(vecs[i].code);
                exp_cnt++;
                exp_last = vecs[i].code;
            end
            cycle();
            ex_valid = 1'b0;
            ex_ovf   = 1'b0;
            ex_flush = 1'b0;
            check($sformatf("vec%0d_wb_valid", i), wb.wb_valid, vecs[i].code != 0);
            check($sformatf("vec%0d_exc_count", i), exc_count, exp_cnt);
            check($sformatf("vec%0d_status_last", i), status_last, exp_last);
            cycle();
            check($sformatf("vec%0d_drained", i), wb.wb_valid, 0);
        end
        check("table_sb_empty", sb.size(), 0);

        // Fill with writeback stalled, then overflow the queue.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        wb.wb_ready = 1'b0;
        drive(5'd0, 5'd1, 1, 3);
        drive(5'd0, 5'd6, 1, 4);
        drive(5'd0, 5'd7, 1, 5);
        drive(5'd5, 5'd0, 1, 2);
        check("fill_full", fifo_full, 1);
        check("fill_no_drop", drop_sticky, 0);
        drive(5'd0, 5'd0, 0, 1);
        check("drop_sticky", drop_sticky, 1);
        check("drop_full", fifo_full, 1);
        check("drop_status_last", status_last, 1);
        check("drop_exc_count", exc_count, 5);
        check("stall_wb_valid", wb.wb_valid, 1);
        check("stall_wb_data", wb.wb_data, 3);
        wb.wb_ready = 1'b1;
        repeat (6) cycle();
        check("drain_sb_empty", sb.size(), 0);
        check("drain_wb_valid", wb.wb_valid, 0);
        check("drain_full", fifo_full, 0);
        check("drain_exc_count", exc_count, 5);

        // clr_sticky together with a fault, then on its own.
        clr_sticky = 1'b1;
        drive(5'd0, 5'd7, 1, 5);
        clr_sticky = 1'b0;
        check("clr_fault_status_last", status_last, 5);
        check("clr_fault_drop_sticky", drop_sticky, 0);
        check("clr_fault_exc_count", exc_count, 6);
        cycle();
        clr_sticky = 1'b1;
        cycle();
        clr_sticky = 1'b0;
        check("clr_status_last", status_last, 0);
        check("clr_drop_sticky", drop_sticky, 0);
        check("clr_exc_count", exc_count, 6);
        check("clr_sb_empty", sb.size(), 0);

        // Full queue: a fault arriving with a pop is accepted at the tail.
        wb.wb_ready = 1'b0;
        drive(5'd0, 5'd0, 1, 1);
        drive(5'd0, 5'd1, 1, 3);
        drive(5'd0, 5'd6, 1, 4);
        drive(5'd0, 5'd7, 1, 5);
        check("pp_full_before", fifo_full, 1);
        wb.wb_ready = 1'b1;
        drive(5'd5, 5'd0, 1, 2);
        wb.wb_ready = 1'b0;
        check("pp_full_after", fifo_full, 1);
        check("pp_no_drop", drop_sticky, 0);
        check("pp_new_head", wb.wb_data, 3);
        check("pp_exc_count", exc_count, 11);
        check("pp_status_last", status_last, 2);
        wb.wb_ready = 1'b1;
        repeat (6) cycle();
        check("pp_sb_empty", sb.size(), 0);
        check("pp_drained", wb.wb_valid, 0);

        // Asynchronous reset while a transfer is stalled.
        wb.wb_ready = 1'b0;
        drive(5'd0, 5'd0, 1, 1);
        check("pre_reset_wb_valid", wb.wb_valid, 1);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        sb.delete();
        cycle();
        reset = 1'b0;
        wb.wb_ready = 1'b1;

        // Long run of div faults to saturate the counter.
        for (int i = 0; i < 300; i++) begin
            ex_valid  = 1'b1;
            ex_opcode = 5'd0;
            ex_alu_op = 5'd7;
            ex_ovf    = 1'b1;
            sb.push_back(5);
            cycle();
        end
        ex_valid = 1'b0;
        ex_ovf   = 1'b0;
        check("sat_exc_count", exc_count, 255);
        check("sat_status_last", status_last, 5);
        check("sat_no_drop", drop_sticky, 0);
        repeat (3) cycle();
        check("sat_sb_empty", sb.size(), 0);
        check("sat_exc_hold", exc_count, 255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
